// File: rtl/ac_motor_vector_time_pipe.sv
// SVM dwell-time pipeline: owns the sample timer and turns U_STR and the
// sector sine weights into T1/T2/T0 with overmodulation clamping.
module ac_motor_vector_time_pipe #(
  parameter int BITS   = 12,
  parameter int F_CLK  = 100000000,
  parameter int F_TAST = 5000,
  parameter int T_W    = 15,
  parameter int CLAMP  = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [BITS-1:0] U_STR,
  input  logic [BITS-1:0] SIN_POSITIVE,
  input  logic [BITS-1:0] SIN_NEGATIVE,
  input  logic            IN_VALID,
  output logic            TICK,
  output logic [T_W-1:0]  T_HIGH,
  output logic [T_W-1:0]  T_LOW,
  output logic [T_W-1:0]  T_ZERO,
  output logic            OUT_VALID,
  output logic            SAT,
  output logic            STALE
);

  localparam int T_TAST = F_CLK / F_TAST;
  localparam int KW = T_W + BITS;
  localparam int PW = T_W + 2 * BITS;
  localparam logic [T_W-1:0] T_MAX  = T_W'(T_TAST);
  localparam logic [T_W-1:0] T_LAST = T_W'(T_TAST - 1);
  localparam logic [T_W:0]   T_EXT  = (T_W + 1)'(T_TAST);

  logic [T_W-1:0]  cnt;
  logic            launch;
  logic            v1, v2, v3;
  logic [KW-1:0]   k1;
  logic [BITS-1:0] sp1, sn1;
  logic [PW-1:0]   pp2, pn2;
  logic [T_W-1:0]  t1_3, t2_3;
  logic [T_W:0]    s3;
  logic [T_W:0]    e, hf, hc;
  logic [T_W-1:0]  nh, nl, nz;
  logic            nsat;

  assign TICK   = (cnt == T_LAST);
  assign launch = TICK & IN_VALID;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (TICK) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Capture and the K product share the TICK edge so results land at c4.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      k1   <= '0;
      sp1  <= '0;
      sn1  <= '0;
      pp2  <= '0;
      pn2  <= '0;
      t1_3 <= '0;
      t2_3 <= '0;
      s3   <= '0;
    end else begin
      v1 <= launch;
      v2 <= v1;
      v3 <= v2;
      if (launch) begin
        k1  <= KW'(T_MAX) * KW'(U_STR);
        sp1 <= SIN_POSITIVE;
        sn1 <= SIN_NEGATIVE;
      end
      if (v1) begin
        pp2 <= PW'(k1) * PW'(sp1);
        pn2 <= PW'(k1) * PW'(sn1);
      end
      if (v2) begin
        t1_3 <= pp2[2*BITS +: T_W];
        t2_3 <= pn2[2*BITS +: T_W];
        s3   <= {1'b0, pp2[2*BITS +: T_W]}
              + {1'b0, pn2[2*BITS +: T_W]};
      end
    end
  end

  // Excess is split floor/ceil between T1 and T2 so the sum stays T_TAST.
  always_comb begin
    e    = s3 - T_EXT;
    hf   = e >> 1;
    hc   = e - hf;
    nh   = t1_3;
    nl   = t2_3;
    nz   = T_MAX - s3[T_W-1:0];
    nsat = 1'b0;
    if (s3 > T_EXT) begin
      nz   = '0;
      nsat = 1'b1;
      if (CLAMP != 0) begin
        if ({1'b0, t1_3} < hf) begin
          nh = '0;
          nl = T_MAX;
        end else if ({1'b0, t2_3} < hc) begin
          nh = T_MAX;
          nl = '0;
        end else begin
          nh = t1_3 - hf[T_W-1:0];
          nl = t2_3 - hc[T_W-1:0];
        end
      end else begin
        nh = (t1_3 > T_MAX) ? T_MAX : t1_3;
        nl = (t2_3 > T_MAX) ? T_MAX : t2_3;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      T_HIGH    <= '0;
      T_LOW     <= '0;
      T_ZERO    <= T_MAX;
      SAT       <= 1'b0;
      OUT_VALID <= 1'b0;
      STALE     <= 1'b0;
    end else begin
      OUT_VALID <= v3;
      if (v3) begin
        T_HIGH <= nh;
        T_LOW  <= nl;
        T_ZERO <= nz;
        SAT    <= nsat;
      end
      if (TICK && !IN_VALID) begin
        STALE <= 1'b1;
      end else if (v3) begin
        STALE <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ac_motor_vector_time_pipe.sv
// Directed bench for ac_motor_vector_time_pipe, run with a 5000-cycle
// sample period (F_TAST=20 kHz) so the whole sequence stays short.
module tb_ac_motor_vector_time_pipe;

  localparam int T_TAST = 5000;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [11:0] U_STR = '0;
  logic [11:0] SIN_POSITIVE = '0;
  logic [11:0] SIN_NEGATIVE = '0;
  logic        IN_VALID = 1'b0;
  logic        TICK;
  logic [14:0] T_HIGH, T_LOW, T_ZERO;
  logic        OUT_VALID, SAT, STALE;

  int checks = 0;
  int errors = 0;

  ac_motor_vector_time_pipe #(
    .BITS(12), .F_CLK(100000000), .F_TAST(20000),
    .T_W(15), .CLAMP(1)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .U_STR(U_STR),
    .SIN_POSITIVE(SIN_POSITIVE),
    .SIN_NEGATIVE(SIN_NEGATIVE),
    .IN_VALID(IN_VALID),
    .TICK(TICK),
    .T_HIGH(T_HIGH), .T_LOW(T_LOW), .T_ZERO(T_ZERO),
    .OUT_VALID(OUT_VALID), .SAT(SAT), .STALE(STALE)
  );

  always #5 CLK = ~CLK;

  // Drives one triple for the next TICK, then watches 8 cycles.
  // lat = cycles from TICK to OUT_VALID (-1 none, -2 no TICK).
  task automatic launch(input logic [11:0] u, sp, sn,
                        input logic iv, output int lat,
                        output int nov, output logic pre_st,
                        output logic st_ov);
    bit found = 0;
    U_STR = u; SIN_POSITIVE = sp; SIN_NEGATIVE = sn;
    IN_VALID = iv;
    lat = -1; nov = 0; pre_st = 1'bx; st_ov = 1'bx;
    for (int i = 0; i < T_TAST + 2; i++) begin
      @(posedge CLK); #1;
      if (TICK) begin found = 1; break; end
    end
    if (!found) begin lat = -2; return; end
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK); #1;
      if (i == 1) begin
        U_STR = 12'hABC; SIN_POSITIVE = 12'h123;
        SIN_NEGATIVE = 12'hFFF; IN_VALID = 1'b1;
      end
      if (i == 3) pre_st = STALE;
      if (OUT_VALID) begin
        nov++;
        if (lat < 0) begin lat = i; st_ov = STALE; end
      end
    end
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset;
    int n = 0;
    bit seen_ov = 0;
    RST_N = 1'b0; IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (T_HIGH !== 0 || T_LOW !== 0 || T_ZERO !== 15'(T_TAST)) begin
      errors++;
      $display("FAIL reset_times: got %0d/%0d/%0d, expected 0/0/%0d",
               T_HIGH, T_LOW, T_ZERO, T_TAST);
    end
    checks++;
    if ({TICK, OUT_VALID, SAT, STALE} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 0000",
               {TICK, OUT_VALID, SAT, STALE});
    end
    @(negedge CLK) RST_N = 1'b1;
    while (n < T_TAST + 2) begin
      @(posedge CLK); #1; n++;
      if (OUT_VALID) seen_ov = 1;
      if (TICK) break;
    end
    checks++;
    if (n !== T_TAST - 1) begin
      errors++;
      $display("FAIL first_tick: got edge %0d, expected %0d",
               n, T_TAST - 1);
    end
    checks++;
    if (seen_ov !== 0 || T_ZERO !== 15'(T_TAST)) begin
      errors++;
      $display("FAIL pre_capture: got ov=%0d tz=%0d, expected 0 %0d",
               seen_ov, T_ZERO, T_TAST);
    end
    @(posedge CLK); #1;
    checks++;
    if (STALE !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL first_stale: got stale=%b ov=%b, expected 1 0",
               STALE, OUT_VALID);
    end
  endtask

  task automatic test_basic;
    int lat, nov; logic ps, so;
    launch(12'd2048, 12'd2048, 12'd0, 1'b1, lat, nov, ps, so);
    checks++;
    if (lat !== 4 || nov !== 1) begin
      errors++;
      $display("FAIL basic_latency: got lat=%0d n=%0d, expected 4 1",
               lat, nov);
    end
    checks++;
    if (T_HIGH !== 1250 || T_LOW !== 0 || T_ZERO !== 3750 ||
        SAT !== 0 || STALE !== 0) begin
      errors++;
      $display("FAIL basic_vals: got %0d/%0d/%0d s%b st%b, expected 1250/0/3750 s0 st0",
               T_HIGH, T_LOW, T_ZERO, SAT, STALE);
    end
  endtask

  task automatic test_stale;
    int lat, nov; logic ps, so;
    launch(12'd4095, 12'd4095, 12'd4095, 1'b0, lat, nov, ps, so);
    checks++;
    if (nov !== 0) begin
      errors++;
      $display("FAIL stale_no_ov: got %0d strobes, expected 0", nov);
    end
    checks++;
    if (STALE !== 1 || T_HIGH !== 1250 || T_LOW !== 0 ||
        T_ZERO !== 3750 || SAT !== 0) begin
      errors++;
      $display("FAIL stale_hold: got st%b %0d/%0d/%0d s%b, expected st1 1250/0/3750 s0",
               STALE, T_HIGH, T_LOW, T_ZERO, SAT);
    end
  endtask

  task automatic test_overmod;
    int lat, nov; logic ps, so;
    launch(12'd4095, 12'd4095, 12'd4095, 1'b1, lat, nov, ps, so);
    checks++;
    if (lat !== 4 || nov !== 1) begin
      errors++;
      $display("FAIL overmod_latency: got lat=%0d n=%0d, expected 4 1",
               lat, nov);
    end
    checks++;
    if (ps !== 1'b1 || so !== 1'b0) begin
      errors++;
      $display("FAIL stale_clear: got pre=%b at_ov=%b, expected 1 0",
               ps, so);
    end
    checks++;
    if (T_HIGH !== 2500 || T_LOW !== 2500 || T_ZERO !== 0 ||
        SAT !== 1) begin
      errors++;
      $display("FAIL overmod_vals: got %0d/%0d/%0d s%b, expected 2500/2500/0 s1",
               T_HIGH, T_LOW, T_ZERO, SAT);
    end
  endtask

  task automatic test_full_scale;
    int lat, nov; logic ps, so;
    launch(12'd4095, 12'd4095, 12'd0, 1'b1, lat, nov, ps, so);
    checks++;
    if (lat !== 4 || T_HIGH !== 4997 || T_LOW !== 0 ||
        T_ZERO !== 3 || SAT !== 0) begin
      errors++;
      $display("FAIL full_scale: got lat%0d %0d/%0d/%0d s%b, expected lat4 4997/0/3 s0",
               lat, T_HIGH, T_LOW, T_ZERO, SAT);
    end
  endtask

  // Odd excess: T1 loses floor(E/2), T2 loses ceil(E/2).
  task automatic test_asym;
    int lat, nov; logic ps, so;
    launch(12'd4095, 12'd4095, 12'd1031, 1'b1, lat, nov, ps, so);
    checks++;
    if (lat !== 4 || T_HIGH !== 4370 || T_LOW !== 630 ||
        T_ZERO !== 0 || SAT !== 1) begin
      errors++;
      $display("FAIL asym_clamp: got lat%0d %0d/%0d/%0d s%b, expected lat4 4370/630/0 s1",
               lat, T_HIGH, T_LOW, T_ZERO, SAT);
    end
    checks++;
    if (int'(T_HIGH) + int'(T_LOW) + int'(T_ZERO) !== T_TAST) begin
      errors++;
      $display("FAIL asym_sum: got %0d, expected %0d",
               int'(T_HIGH) + int'(T_LOW) + int'(T_ZERO), T_TAST);
    end
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    bit seen_ov = 0;
    int n = 0;
    U_STR = 12'd2048; SIN_POSITIVE = 12'd2048;
    SIN_NEGATIVE = 12'd0; IN_VALID = 1'b1;
    for (int i = 0; i < T_TAST + 2; i++) begin
      @(posedge CLK); #1;
      if (TICK) begin found = 1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_tick: got no TICK, expected one");
    end
    IN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    checks++;
    if (T_HIGH !== 0 || T_LOW !== 0 || T_ZERO !== 15'(T_TAST) ||
        SAT !== 0 || STALE !== 0 || OUT_VALID !== 0) begin
      errors++;
      $display("FAIL mid_reset: got %0d/%0d/%0d s%b st%b ov%b, expected 0/0/%0d 0 0 0",
               T_HIGH, T_LOW, T_ZERO, SAT, STALE, OUT_VALID, T_TAST);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    while (n < T_TAST + 2) begin
      @(posedge CLK); #1; n++;
      if (OUT_VALID) seen_ov = 1;
      if (TICK) break;
    end
    checks++;
    if (n !== T_TAST - 1 || seen_ov !== 0) begin
      errors++;
      $display("FAIL mid_restart: got edge %0d ov=%0d, expected %0d 0",
               n, seen_ov, T_TAST - 1);
    end
    checks++;
    if (T_HIGH !== 0 || T_ZERO !== 15'(T_TAST)) begin
      errors++;
      $display("FAIL mid_discard: got %0d/%0d, expected 0/%0d",
               T_HIGH, T_ZERO, T_TAST);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stale();
    test_overmod();
    test_full_scale();
    test_asym();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
